// File: rtl/data_out_uart_pkg.sv
// rtl/data_out_uart_pkg.sv - shared serializer state type and default sizing for the Data_out UART transmitter
package data_out_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_FIFO_DEPTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO; full comes from the registered occupancy count
module sync_fifo
  import data_out_uart_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Push is gated by the registered full, so a same-edge pop never frees a slot early.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_out_uart_tx.sv
// rtl/data_out_uart_tx.sv - buffers 32-bit core Data_out words and sends them as four 8N1 bytes, LSB byte first
module data_out_uart_tx
  import data_out_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        overflow,
  output logic        busy,
  output logic        tx
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  tx_state_e     state_next;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [2:0]    bit_inc;
  logic [1:0]    byte_idx;
  logic [1:0]    byte_next;
  logic [31:0]   word;
  logic [31:0]   word_next;
  logic [31:0]   fifo_data;
  logic [7:0]    cur_byte;
  logic          tx_next;
  logic          pop;
  logic          empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty)
  );

  assign busy     = (state != ST_IDLE) || !empty;
  assign cur_byte = word[{byte_idx, 3'b000} +: 8];
  assign bit_inc  = bit_idx + 3'd1;

  // tx is registered, so the level computed here is the one for the state being entered.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    word_next  = word;
    tx_next    = 1'b1;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          word_next  = fifo_data;
          byte_next  = 2'd0;
          bit_next   = 3'd0;
          baud_next  = '0;
          state_next = ST_START;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = ST_DATA;
          tx_next    = cur_byte[0];
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      ST_DATA: begin
        tx_next = cur_byte[bit_idx];
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_inc;
            tx_next  = cur_byte[bit_inc];
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (byte_idx != 2'd3) begin
            byte_next  = byte_idx + 2'd1;
            state_next = ST_START;
            tx_next    = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      word     <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud     <= baud_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      word     <= word_next;
      tx       <= tx_next;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/data_out_uart_tx.md
DATA_OUT_UART_TX -- requirements
Module: data_out_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (>=2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8: words buffered (power of 2, >=2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: capture strobe for the core's Data_out word.
REQ-006 The block SHALL have port wr_data, input, 32 bits: result word from the RISC_V core's Data_out.
REQ-007 The block SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH words.
REQ-008 The block SHALL have port overflow, output, 1 bit: sticky flag set when a write was dropped.
REQ-009 The block SHALL have port busy, output, 1 bit: serializer not IDLE or FIFO not empty.
REQ-010 The block SHALL have port tx, output, 1 bit: UART 8N1 serial line, idle high.

Function
REQ-011 FIFO push SHALL occur on a rising edge with wr_en=1 and full=0; wr_data is stored unmodified.
REQ-012 A write with wr_en=1 and full=1 SHALL be dropped, leave FIFO contents unchanged, and set overflow on that edge.
REQ-013 full SHALL derive from the registered occupancy count; a same-edge pop SHALL NOT admit a push while full=1.
REQ-014 Occupancy SHALL be tracked with count width clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
REQ-015 Serializer states SHALL be IDLE, START, DATA, STOP.
REQ-016 In IDLE with FIFO non-empty, the serializer SHALL pop one word, latch it, set byte_idx=0, and enter START on the same edge.
REQ-017 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA SHALL drive 8 bits of the current byte LSB first, each held CLKS_PER_BIT cycles, then enter STOP.
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; if byte_idx<3, increment byte_idx and enter START, else enter IDLE.
REQ-020 Bytes SHALL go out little-endian: byte 0 = wr_data[7:0] first, byte 3 = wr_data[31:24] last.
REQ-021 One word SHALL occupy exactly 40*CLKS_PER_BIT cycles of tx time.
REQ-022 IDLE SHALL last one cycle when the FIFO is non-empty, so back-to-back words are separated by one idle-high cycle.
REQ-023 tx SHALL be a registered output.
REQ-024 Latency: wr_en into an empty, idle block on edge N SHALL make tx fall on edge N+1 and stay low CLKS_PER_BIT cycles.
REQ-025 A simultaneous push and pop SHALL keep the count unchanged and leave both data words intact.

Reset
REQ-026 While rst=1 on an edge, the block SHALL force tx=1, full=0, overflow=0, busy=0, count=0, pointers=0, state=IDLE, bit and baud counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard all buffered words; tx returns high on that edge.
REQ-028 FIFO storage contents SHALL NOT require reset.
REQ-029 overflow SHALL clear only on reset.

Structure
REQ-030 A shared package data_out_uart_pkg SHALL hold the serializer state enumeration and the default CLKS_PER_BIT and FIFO_DEPTH constants.
REQ-031 The FIFO SHALL be a sub-module named sync_fifo, parameterised on width and depth; the serializer FSM stays in the top module.
REQ-032 The block SHALL connect with wr_data driven from RISC_V Data_out and wr_en driven from the core's write/valid strobe.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Reset: hold rst=1 for 3 cycles mid-frame -> tx=1, busy=0, full=0, overflow=0 on the first edge with rst high.
REQ-034 Single word: write 0xA5C3_0F81 once -> tx falls at N+1; frames carry 0x81, 0x0F, 0xC3, 0xA5 LSB first with stop bits; 160 cycles total; busy drops after.
REQ-035 Back-to-back words: write 0x0000_0001 then 0xFFFF_FFFF on consecutive cycles -> both decode correctly, exactly one idle-high cycle between them.
REQ-036 Overflow: hold wr_en for 6 cycles with data 1..6 while idle -> full=1 at the expected edge, overflow=1; decoder receives the words that were accepted (1..5 minus drops per REQ-013) with no corruption.
REQ-037 Concurrent push/pop: write while the serializer pops from a full FIFO -> write dropped, overflow=1, count stays consistent.
REQ-038 Reset mid-byte: assert rst during DATA of byte 2 -> tx high next edge; a new word after reset transmits cleanly.
